tank_pump_sched: RTL and testbench
==================================

# tank_pump_sched

Two-pump scheduler for the water-tank controller. It debounces the lower (I) and upper (S) level sensors and runs a Moore state machine that drives pumps B1/B2. The machine rotates the lead pump on every fill cycle, staggers the second pump's start, enforces a minimum run time and substitutes around faulted pumps. It sits between the raw tank sensors and the pump contactor drivers, and raises `alarm` on inconsistent sensors or a double pump fault.

## Interface
- `DEB_CYC`, 4: consecutive identical raw samples needed before a sensor change is accepted (≥1).
- `STAGGER`, 3: cycles the lead pump runs alone at EMPTY before the lag pump joins (≥1).
- `MIN_ON`, 8: minimum cycles pumping, counted from leaving IDLE, before FULL may stop the pumps (≥1).
- `CNT_W`, 8: width of the internal counters; must hold max(DEB_CYC, STAGGER, MIN_ON).
- `clk` input 1: clock; all state changes on the rising edge.
- `nReset` input 1: reset, asynchronous, active-low.
- `I` input 1: raw lower sensor, 1 = water above the lower mark.
- `S` input 1: raw upper sensor, 1 = water above the upper mark.
- `f1` input 1: pump 1 fault feedback, active-high, sampled synchronously.
- `f2` input 1: pump 2 fault feedback, active-high, sampled synchronously.
- `B1` output 1: pump 1 run command, registered.
- `B2` output 1: pump 2 run command, registered.
- `alarm` output 1: fault indication, registered.
- `lead` output 1: current lead pump, 0 = B1, 1 = B2, registered.

## Operation
- **Debounce.** One counter per sensor. The counter clears whenever the raw input equals the debounced value or differs from the previous raw sample. When it reaches DEB_CYC, the debounced value takes the raw value.
- **Level decode** from debounced {Id, Sd}:
  - 11 = FULL
  - 10 = HALF
  - 00 = EMPTY
  - 01 = INVALID
- **States and transitions:**
  - IDLE: B1 = B2 = 0.
    - HALF or EMPTY → LEAD.
    - INVALID → FAULT.
  - LEAD: lead pump on, lag pump off.
    - INVALID → FAULT.
    - FULL with run_cnt ≥ MIN_ON → IDLE, and `lead` toggles.
    - FULL with run_cnt < MIN_ON → stay in LEAD until run_cnt = MIN_ON.
    - EMPTY with stag_cnt = STAGGER → BOTH.
  - BOTH: both pumps on.
    - INVALID → FAULT.
    - FULL with run_cnt ≥ MIN_ON → IDLE, and `lead` toggles.
    - HALF → LEAD; the lag pump turns off immediately.
  - FAULT: B1 = B2 = 0, alarm = 1.
    - Exits to IDLE when the level is not INVALID and at least one of f1/f2 is 0.
    - `lead` is unchanged on exit.
- **Counters:**
  - run_cnt clears in IDLE and FAULT, increments each cycle in LEAD/BOTH, and saturates at MIN_ON.
  - stag_cnt clears on entry to LEAD and whenever the level is not EMPTY; it increments in LEAD while EMPTY and saturates at STAGGER.
- **Pump faults:**
  - A faulted pump's output is forced to 0 in every state.
  - In LEAD or BOTH, if the lead pump is faulted and the lag pump is healthy, `lead` toggles on that edge. This substitution does not count as a fill-cycle rotation.
  - f1 = f2 = 1 in any state → FAULT.
- **Precedence when events coincide in one cycle:** double fault > INVALID > FULL stop > fault substitution > stagger promotion.
- **Reset values:**
  - state = IDLE, B1 = 0, B2 = 0, alarm = 0, lead = 0.
  - Debounced Id = Sd = 1, so the level reads FULL and no pump starts until a sensor change is confirmed.
  - All counters = 0.
  - Asserting reset mid-fill stops both pumps immediately (asynchronously).

## Timing
- All outputs are Moore functions of registered state, updated on the same edge as the state.
- Raw sensor change to debounced change: DEB_CYC rising edges of stable input.
- Debounced change to output change: +1 edge. Total raw-to-pump latency is DEB_CYC + 1 cycles.
- Pump fault to pump output 0: 1 edge, since f1/f2 are sampled and the output register follows.
- Lag pump start at EMPTY: STAGGER + 1 edges after entering LEAD.
- Minimum pumping interval: MIN_ON cycles, from the first cycle a pump is on to the edge leaving for IDLE.
- A raw glitch shorter than DEB_CYC cycles causes no change.

## Test plan
Parameters for all scenarios: DEB_CYC = 4, STAGGER = 3, MIN_ON = 8.

1. Release reset with I = S = 1 → B1 = B2 = 0 and alarm = 0 for 20 cycles.
2. Drive I = S = 0 from idle → B1 = 1 at edge 5; B2 = 1 at edge 9. Then drive I = S = 1 → both pumps off once MIN_ON is met and the debounced FULL is seen; `lead` becomes 1.
3. Second fill with I = 1, S = 0 → only B2 = 1; after FULL, B2 = 0 and `lead` = 0.
4. Pulse S = 1 for 3 cycles while I = 0 → no state change. Hold I = 0, S = 1 for 4 cycles → alarm = 1, B1 = B2 = 0. Restore I = 1, S = 1 → alarm = 0 one cycle after the debounced value updates.
5. Assert f1 while B1 is leading in LEAD → next edge B1 = 0, B2 = 1, `lead` = 1. Then assert f2 as well → FAULT, alarm = 1.
6. Assert nReset = 0 mid-BOTH → B1 = B2 = 0 asynchronously (same cycle). Release → IDLE, `lead` = 0.

Source files
------------

// File: rtl/tank_pump_sched_if.sv
// Sensor, fault-feedback and pump-command bundle between the tank front end
// and the two-pump scheduler.
interface tank_pump_sched_if;
  logic I;
  logic S;
  logic f1;
  logic f2;
  logic B1;
  logic B2;
  logic alarm;
  logic lead;

  modport master (output I, S, f1, f2, input B1, B2, alarm, lead);
  modport slave  (input I, S, f1, f2, output B1, B2, alarm, lead);
endinterface

// File: rtl/tank_pump_sched.sv
// Two-pump water-tank scheduler: debounced level sensors drive a Moore FSM
// with lead rotation, lag-pump stagger, minimum run time and fault substitution.
module tank_pump_sched #(
  parameter int DEB_CYC = 4,
  parameter int STAGGER = 3,
  parameter int MIN_ON  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              nReset,
  tank_pump_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_BOTH  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] STAG_LIM = CNT_W'(STAGGER);
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state_r, state_s;
  logic [1:0]             raw_s, raw_prev_r, deb_r, deb_s;
  logic [1:0][CNT_W-1:0]  deb_cnt_r, deb_cnt_s;
  logic [CNT_W-1:0]       run_cnt_r, run_cnt_s;
  logic [CNT_W-1:0]       stag_cnt_r, stag_cnt_s;
  logic                   lead_r, lead_s;
  logic                   b1_r, b1_s, b2_r, b2_s, alarm_r, alarm_s;
  logic                   lvl_full_s, lvl_half_s, lvl_empty_s, lvl_invalid_s;
  logic                   dbl_flt_s, sub_s, stop_ok_s, promote_s;
  logic                   pump1_on_s, pump2_on_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    if (v >= lim) sat_inc = lim;
    else          sat_inc = v + CNT_ONE;
  endfunction

  assign raw_s = {bus.I, bus.S};

  // The first differing sample already counts as one, so a change lands after DEB_CYC edges.
  always_comb begin
    deb_s     = deb_r;
    deb_cnt_s = '0;
    for (int k = 0; k < 2; k++) begin
      if (raw_s[k] == deb_r[k])          deb_cnt_s[k] = '0;
      else if (raw_s[k] != raw_prev_r[k]) deb_cnt_s[k] = CNT_ONE;
      else                                deb_cnt_s[k] = deb_cnt_r[k] + CNT_ONE;
      if (deb_cnt_s[k] >= DEB_LIM) begin
        deb_s[k]     = raw_s[k];
        deb_cnt_s[k] = '0;
      end else begin
        deb_s[k]     = deb_r[k];
      end
    end
  end

  assign lvl_full_s    = (deb_r == 2'b11);
  assign lvl_half_s    = (deb_r == 2'b10);
  assign lvl_empty_s   = (deb_r == 2'b00);
  assign lvl_invalid_s = (deb_r == 2'b01);
  assign dbl_flt_s     = bus.f1 & bus.f2;
  assign sub_s         = lead_r ? (bus.f2 & ~bus.f1) : (bus.f1 & ~bus.f2);
  assign stop_ok_s     = (run_cnt_r >= RUN_LIM);
  assign promote_s     = lvl_empty_s && (stag_cnt_r == STAG_LIM);

  // Next state and lead; branch order encodes event precedence.
  always_comb begin
    state_s = state_r;
    lead_s  = lead_r;
    if (dbl_flt_s) begin
      state_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lvl_invalid_s)                  state_s = ST_FAULT;
          else if (lvl_half_s || lvl_empty_s) state_s = ST_LEAD;
          else                                state_s = ST_IDLE;
        end
        ST_LEAD: begin
          if (lvl_invalid_s) begin
            state_s = ST_FAULT;
          end else if (lvl_full_s && stop_ok_s) begin
            state_s = ST_IDLE;
            lead_s  = ~lead_r;
          end else if (sub_s) begin
            lead_s  = ~lead_r;
          end else if (promote_s) begin
            state_s = ST_BOTH;
          end else begin
            state_s = ST_LEAD;
          end
        end
        ST_BOTH: begin
          if (lvl_invalid_s) begin
            state_s = ST_FAULT;
          end else if (lvl_full_s && stop_ok_s) begin
            state_s = ST_IDLE;
            lead_s  = ~lead_r;
          end else begin
            if (sub_s)      lead_s  = ~lead_r;
            else            lead_s  = lead_r;
            if (lvl_half_s) state_s = ST_LEAD;
            else            state_s = ST_BOTH;
          end
        end
        ST_FAULT: begin
          if (!lvl_invalid_s) state_s = ST_IDLE;
          else                state_s = ST_FAULT;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Run time starts counting on the edge that leaves IDLE.
  always_comb begin
    run_cnt_s  = '0;
    stag_cnt_s = '0;
    if (state_s == ST_LEAD || state_s == ST_BOTH) run_cnt_s = sat_inc(run_cnt_r, RUN_LIM);
    else                                          run_cnt_s = '0;
    if (state_s == ST_LEAD && state_r == ST_LEAD && lvl_empty_s)
      stag_cnt_s = sat_inc(stag_cnt_r, STAG_LIM);
    else
      stag_cnt_s = '0;
  end

  // Pump commands decoded from the next state, masked by the sampled fault inputs.
  always_comb begin
    pump1_on_s = (state_s == ST_BOTH) || (state_s == ST_LEAD && !lead_s);
    pump2_on_s = (state_s == ST_BOTH) || (state_s == ST_LEAD &&  lead_s);
    b1_s       = pump1_on_s & ~bus.f1;
    b2_s       = pump2_on_s & ~bus.f2;
    alarm_s    = (state_s == ST_FAULT);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= ST_IDLE;
      raw_prev_r <= 2'b11;
      deb_r      <= 2'b11;
      deb_cnt_r  <= '0;
      run_cnt_r  <= '0;
      stag_cnt_r <= '0;
      lead_r     <= 1'b0;
      b1_r       <= 1'b0;
      b2_r       <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      raw_prev_r <= raw_s;
      deb_r      <= deb_s;
      deb_cnt_r  <= deb_cnt_s;
      run_cnt_r  <= run_cnt_s;
      stag_cnt_r <= stag_cnt_s;
      lead_r     <= lead_s;
      b1_r       <= b1_s;
      b2_r       <= b2_s;
      alarm_r    <= alarm_s;
    end
  end

  assign bus.B1    = b1_r;
  assign bus.B2    = b2_r;
  assign bus.alarm = alarm_r;
  assign bus.lead  = lead_r;

endmodule

// File: tb/tb_tank_pump_sched.sv
// Directed plus randomized bench for tank_pump_sched against a run-length /
// mode-based reference model of the scheduling rules.
module tb_tank_pump_sched;
  localparam int DEB_CYC = 4;
  localparam int STAGGER = 3;
  localparam int MIN_ON  = 8;
  localparam int M_IDLE = 0, M_SINGLE = 1, M_DUAL = 2, M_FAULT = 3;

  logic clk;
  logic nReset;
  int   checks   = 0;
  int   failures = 0;

  tank_pump_sched_if bus ();

  tank_pump_sched #(.DEB_CYC(DEB_CYC), .STAGGER(STAGGER), .MIN_ON(MIN_ON), .CNT_W(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: sensor run lengths, pumping mode, edges spent pumping / at EMPTY.
  bit m_deb[2];
  bit m_last[2];
  int m_len[2];
  int m_mode;
  bit m_ld;
  int m_pump_edges;
  int m_empty_edges;
  bit m_b1, m_b2, m_alarm;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_deb[k] = 1'b1; m_last[k] = 1'b1; m_len[k] = 0;
    end
    m_mode = M_IDLE; m_ld = 1'b0; m_pump_edges = 0; m_empty_edges = 0;
    m_b1 = 1'b0; m_b2 = 1'b0; m_alarm = 1'b0;
  endtask

  task automatic model_step();
    bit raw[2];
    bit fa, fb, sub, stop_ok;
    int lvl, prev_mode;
    raw[1] = bus.I; raw[0] = bus.S; fa = bus.f1; fb = bus.f2;
    lvl       = 2 * int'(m_deb[1]) + int'(m_deb[0]);  // 3 FULL, 2 HALF, 0 EMPTY, 1 INVALID
    stop_ok   = (m_pump_edges >= MIN_ON);
    sub       = m_ld ? (fb && !fa) : (fa && !fb);
    prev_mode = m_mode;
    if (fa && fb) m_mode = M_FAULT;
    else if (m_mode == M_IDLE) begin
      if (lvl == 1) m_mode = M_FAULT;
      else if (lvl != 3) m_mode = M_SINGLE;
    end else if (m_mode == M_FAULT) begin
      if (lvl != 1) m_mode = M_IDLE;
    end else if (lvl == 1) m_mode = M_FAULT;
    else if (lvl == 3 && stop_ok) begin
      m_mode = M_IDLE; m_ld = !m_ld;
    end else if (m_mode == M_SINGLE) begin
      if (sub) m_ld = !m_ld;
      else if (lvl == 0 && m_empty_edges >= STAGGER) m_mode = M_DUAL;
    end else begin
      if (sub) m_ld = !m_ld;
      if (lvl == 2) m_mode = M_SINGLE;
    end
    if (m_mode == M_SINGLE || m_mode == M_DUAL) m_pump_edges++;
    else m_pump_edges = 0;
    if (m_mode == M_SINGLE && prev_mode == M_SINGLE && lvl == 0) m_empty_edges++;
    else m_empty_edges = 0;
    for (int k = 0; k < 2; k++) begin
      if (raw[k] == m_last[k]) m_len[k]++;
      else m_len[k] = 1;
      m_last[k] = raw[k];
      if (raw[k] != m_deb[k] && m_len[k] >= DEB_CYC) m_deb[k] = raw[k];
    end
    m_b1    = ((m_mode == M_SINGLE && !m_ld) || m_mode == M_DUAL) && !fa;
    m_b2    = ((m_mode == M_SINGLE &&  m_ld) || m_mode == M_DUAL) && !fb;
    m_alarm = (m_mode == M_FAULT);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_bit({tag, "_B1"},    bus.B1,    m_b1);
    check_bit({tag, "_B2"},    bus.B2,    m_b2);
    check_bit({tag, "_alarm"}, bus.alarm, m_alarm);
    check_bit({tag, "_lead"},  bus.lead,  m_ld);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    int n;
    int r;
    int seg_len;
    nReset = 1'b1;
    bus.I = 1'b1; bus.S = 1'b1; bus.f1 = 1'b0; bus.f2 = 1'b0;
    model_reset();
    #3 nReset = 1'b0;
    #1;
    check_bit("rst_B1", bus.B1, 1'b0);
    check_bit("rst_B2", bus.B2, 1'b0);
    check_bit("rst_alarm", bus.alarm, 1'b0);
    check_bit("rst_lead", bus.lead, 1'b0);
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;

    // 1: idle at FULL
    repeat (20) tick("t1");
    check_bit("t1_pumps_off", bus.B1 | bus.B2, 1'b0);
    check_bit("t1_alarm", bus.alarm, 1'b0);

    // 2: empty fill, lead B1, lag after stagger, stop at FULL
    bus.I = 1'b0; bus.S = 1'b0;
    repeat (4) tick("t2");
    check_bit("t2_B1_edge4", bus.B1, 1'b0);
    tick("t2");
    check_bit("t2_B1_edge5", bus.B1, 1'b1);
    check_bit("t2_B2_edge5", bus.B2, 1'b0);
    repeat (3) tick("t2");
    check_bit("t2_B2_edge8", bus.B2, 1'b0);
    tick("t2");
    check_bit("t2_B2_edge9", bus.B2, 1'b1);
    bus.I = 1'b1; bus.S = 1'b1;
    n = 0;
    while ((bus.B1 || bus.B2) && n < 40) begin tick("t2_stop"); n++; end
    check_bit("t2_stopped", bus.B1 | bus.B2, 1'b0);
    check_bit("t2_lead", bus.lead, 1'b1);

    // 3: half fill uses B2 only, lead rotates back
    bus.I = 1'b1; bus.S = 1'b0;
    repeat (4) tick("t3");
    check_bit("t3_B2_edge4", bus.B2, 1'b0);
    tick("t3");
    check_bit("t3_B2_edge5", bus.B2, 1'b1);
    check_bit("t3_B1_edge5", bus.B1, 1'b0);
    repeat (10) tick("t3");
    check_bit("t3_B1_half", bus.B1, 1'b0);
    bus.I = 1'b1; bus.S = 1'b1;
    n = 0;
    while (bus.B2 && n < 40) begin tick("t3_stop"); n++; end
    check_bit("t3_stopped", bus.B2, 1'b0);
    check_bit("t3_lead", bus.lead, 1'b0);

    // 4: short S glitch ignored, sustained inconsistency raises alarm
    bus.I = 1'b0; bus.S = 1'b0;
    repeat (14) tick("t4_fill");
    check_bit("t4_both_on", bus.B1 & bus.B2, 1'b1);
    bus.S = 1'b1;
    repeat (3) tick("t4_glitch");
    bus.S = 1'b0;
    repeat (4) tick("t4_glitch");
    check_bit("t4_glitch_B1", bus.B1, 1'b1);
    check_bit("t4_glitch_B2", bus.B2, 1'b1);
    check_bit("t4_glitch_alarm", bus.alarm, 1'b0);
    bus.S = 1'b1;
    repeat (4) tick("t4_inv");
    check_bit("t4_alarm_edge4", bus.alarm, 1'b0);
    tick("t4_inv");
    check_bit("t4_alarm_edge5", bus.alarm, 1'b1);
    check_bit("t4_fault_pumps", bus.B1 | bus.B2, 1'b0);
    bus.I = 1'b1;
    repeat (4) tick("t4_clr");
    check_bit("t4_alarm_held", bus.alarm, 1'b1);
    tick("t4_clr");
    check_bit("t4_alarm_clr", bus.alarm, 1'b0);
    check_bit("t4_lead", bus.lead, 1'b0);

    // 5: fault substitution, double fault, then minimum run time boundary
    bus.I = 1'b1; bus.S = 1'b0;
    repeat (5) tick("t5");
    check_bit("t5_B1_lead", bus.B1, 1'b1);
    bus.f1 = 1'b1;
    tick("t5_sub");
    check_bit("t5_sub_B1", bus.B1, 1'b0);
    check_bit("t5_sub_B2", bus.B2, 1'b1);
    check_bit("t5_sub_lead", bus.lead, 1'b1);
    bus.f2 = 1'b1;
    tick("t5_dbl");
    check_bit("t5_dbl_alarm", bus.alarm, 1'b1);
    check_bit("t5_dbl_pumps", bus.B1 | bus.B2, 1'b0);
    bus.f1 = 1'b0; bus.f2 = 1'b0; bus.I = 1'b1; bus.S = 1'b1;
    repeat (9) tick("t5_min");
    check_bit("t5_min_B2_edge9", bus.B2, 1'b1);
    tick("t5_min");
    check_bit("t5_min_B2_edge10", bus.B2, 1'b0);
    check_bit("t5_min_lead", bus.lead, 1'b0);

    // 6: asynchronous reset while both pumps run
    bus.I = 1'b0; bus.S = 1'b0;
    repeat (9) tick("t6");
    check_bit("t6_both_on", bus.B1 & bus.B2, 1'b1);
    #2 nReset = 1'b0;
    #1;
    check_bit("t6_async_B1", bus.B1, 1'b0);
    check_bit("t6_async_B2", bus.B2, 1'b0);
    model_reset();
    bus.I = 1'b1; bus.S = 1'b1;
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
    repeat (3) tick("t6_post");
    check_bit("t6_post_lead", bus.lead, 1'b0);

    // 7: randomized level segments and sporadic pump faults
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 15);
      if (r < 5)       begin bus.I = 1'b1; bus.S = 1'b1; end
      else if (r < 9)  begin bus.I = 1'b1; bus.S = 1'b0; end
      else if (r < 14) begin bus.I = 1'b0; bus.S = 1'b0; end
      else             begin bus.I = 1'b0; bus.S = 1'b1; end
      bus.f1 = ($urandom_range(0, 9) == 0);
      bus.f2 = ($urandom_range(0, 9) == 0);
      seg_len = $urandom_range(1, 12);
      repeat (seg_len) tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
